// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Takes a little-endian byte stream
//   over a valid/ready handshake, packs each group of four bytes into a 32-bit
//   instruction word and writes it at BASE_ADDR, BASE_ADDR+4, ...
//
// Parameters
//   BASE_ADDR    byte address of the first word (multiple of 4)
//   MAX_WORDS    capacity in words; larger requests are rejected with err
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          begin a load (sampled only while idle)
//   num_words      words to load, latched on an accepted start
//   byte_valid     byte_data holds a valid stream byte
//   byte_data      stream byte
//   byte_ready     loader takes a byte this cycle
//   wr_en          one-cycle write strobe per assembled word
//   wr_addr        byte address of the write (0 when wr_en is low)
//   wr_data        assembled word (0 when wr_en is low)
//   busy           load in progress (receiving or writing)
//   done           one-cycle end-of-load pulse
//   err            last start was rejected; valid with done, cleared by start
//   words_loaded   words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  words_loaded
);

    localparam logic [6:0] MAX_W = 7'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q;
    logic [6:0]  word_idx_q;
    logic [6:0]  num_q;
    logic [6:0]  loaded_q;
    logic [31:0] word_q;
    logic        err_q;

    logic too_big;
    logic empty_req;
    logic last_byte;
    logic last_word;

    assign too_big   = num_words > MAX_W;
    assign empty_req = num_words == 7'd0;
    assign last_byte = byte_idx_q == 2'd3;
    assign last_word = (loaded_q + 7'd1) == num_q;

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (empty_req || too_big) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_valid && last_byte) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = last_word ? DONE : RECV;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            word_idx_q <= 7'd0;
            num_q      <= 7'd0;
            loaded_q   <= 7'd0;
            word_q     <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // err reflects only the most recent start.
                        err_q <= too_big;
                        if (!empty_req && !too_big) begin
                            num_q      <= num_words;
                            byte_idx_q <= 2'd0;
                            word_idx_q <= 7'd0;
                            loaded_q   <= 7'd0;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        // Little-endian: byte k lands in bits [8k+7:8k].
                        word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
                        byte_idx_q                        <= byte_idx_q + 2'd1;
                    end
                end
                WRITE: begin
                    word_idx_q <= word_idx_q + 7'd1;
                    loaded_q   <= loaded_q + 7'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and write strobe are masked by reset so that nothing is
    // consumed or written in the cycle reset is asserted.
    always_comb begin
        byte_ready = (state_q == RECV) && !reset;
        wr_en      = (state_q == WRITE) && !reset;
        wr_addr    = 32'd0;
        wr_data    = 32'd0;
        if (wr_en) begin
            wr_addr = BASE_ADDR + {23'd0, word_idx_q, 2'b00};
            wr_data = word_q;
        end
    end

    assign busy         = (state_q == RECV) || (state_q == WRITE);
    assign done         = state_q == DONE;
    assign err          = err_q;
    assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  num_words = 7'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;

    logic        byte_ready_a, wr_en_a, busy_a, done_a, err_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic [6:0]  wl_a;
    logic        byte_ready_b, wr_en_b, busy_b, done_b, err_b;
    logic [31:0] wr_addr_b, wr_data_b;
    logic [6:0]  wl_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    int last_wl = 0;
    wr_t exp_q[$];
    logic [7:0] stim[$];
    vec_t tbl[6];

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(32)) dut_a (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a),
        .done(done_a), .err(err_a), .words_loaded(wl_a)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0010), .MAX_WORDS(32)) dut_b (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
        .done(done_b), .err(err_b), .words_loaded(wl_b)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write scoreboard: every strobe must match the next expected word.
    always @(negedge clk) begin
        if (wr_en_a === 1'b1 || wr_en_b === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_data", wr_data_a, e.data);
                check("wr_addr", wr_addr_a, 32'(4 * e.idx));
                check("wr_en_b", 32'(wr_en_b), 32'd1);
                check("wr_data_b", wr_data_b, e.data);
                check("wr_addr_b", wr_addr_b, 32'h10 + 32'(4 * e.idx));
                check("ready_in_write", 32'(byte_ready_a), 32'd0);
                check("ready_in_write_b", 32'(byte_ready_b), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vmode 0: always valid, 1: valid every other cycle, 2: random gaps.
    task automatic feed(input int first, input int count, input int vmode);
        int k = 0;
        int cyc = 0;
        bit acc;
        while (k < count && cyc < 1000) begin
            case (vmode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (cyc % 2 == 0);
                default: byte_valid = ($urandom_range(0, 9) < 7);
            endcase
            byte_data = byte_valid ? stim[first + k] : 8'($urandom);
            @(negedge clk);
            acc = byte_valid && byte_ready_a;
            tick();
            if (acc) k++;
            cyc++;
        end
        byte_valid = 1'b0;
        if (k < count) check("feed_timeout", 32'(k), 32'(count));
    endtask

    // Called one cycle after the last byte was accepted.
    task automatic finish_load(input int n, input int wr0);
        @(negedge clk);
        check("last_wr_en", 32'(wr_en_a), 32'd1);
        tick();
        @(negedge clk);
        check("done", 32'(done_a), 32'd1);
        check("done_b", 32'(done_b), 32'd1);
        check("err", 32'(err_a), 32'd0);
        check("words_loaded", 32'(wl_a), 32'(n));
        check("words_loaded_b", 32'(wl_b), 32'(n));
        check("write_count", 32'(n_wr - wr0), 32'(n));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        tick();
        @(negedge clk);
        check("done_pulse", 32'(done_a), 32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_busy_b", 32'(busy_b), 32'd0);
        tick();
        last_wl = n;
    endtask

    // Caller fills stim and exp_q.
    task automatic do_load(input int n, input int vmode);
        int wr0;
        wr0 = n_wr;
        start = 1'b1;
        num_words = 7'(n);
        tick();
        start = 1'b0;
        @(negedge clk);
        if (n == 0 || n > 32) begin
            check("rej_done", 32'(done_a), 32'd1);
            check("rej_err", 32'(err_a), 32'(n > 32));
            check("rej_err_b", 32'(err_b), 32'(n > 32));
            check("rej_ready", 32'(byte_ready_a), 32'd0);
            check("rej_wl", 32'(wl_a), 32'(last_wl));
            tick();
            @(negedge clk);
            check("rej_done_pulse", 32'(done_a), 32'd0);
            check("rej_busy", 32'(busy_a), 32'd0);
            check("rej_no_write", 32'(n_wr - wr0), 32'd0);
            tick();
        end else begin
            check("start_ready", 32'(byte_ready_a), 32'd1);
            check("start_busy", 32'(busy_a), 32'd1);
            tick();
            feed(0, 4 * n, vmode);
            finish_load(n, wr0);
        end
    endtask

    task automatic rand_load(input int n, input int vmode);
        stim.delete();
        exp_q.delete();
        if (n >= 1 && n <= 32) begin
            for (int i = 0; i < n; i++) begin
                logic [7:0] b[4];
                for (int j = 0; j < 4; j++) begin
                    b[j] = 8'($urandom);
                    stim.push_back(b[j]);
                end
                exp_q.push_back('{i, {b[3], b[2], b[1], b[0]}});
            end
        end
        do_load(n, vmode);
    endtask

    initial begin
        tbl[0] = '{8'h93, 8'h00, 8'hA0, 8'h00, 32'h00A00093};
        tbl[1] = '{8'h83, 8'h00, 8'h10, 8'h00, 32'h00100083};
        tbl[2] = '{8'h03, 8'h01, 8'h20, 8'h00, 32'h00200103};
        tbl[3] = '{8'hB3, 8'h81, 8'h20, 8'h00, 32'h002081B3};
        tbl[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        tbl[5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF};

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", 32'(byte_ready_a), 32'd0);
        check("rst_wr_en", 32'(wr_en_a), 32'd0);
        check("rst_wr_addr_b", wr_addr_b, 32'd0);
        check("rst_wr_data", wr_data_a, 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_wl", 32'(wl_a), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single-word loads from the vector table, bytes back-to-back.
        foreach (tbl[i]) begin
            stim.delete();
            exp_q.delete();
            stim.push_back(tbl[i].b0);
            stim.push_back(tbl[i].b1);
            stim.push_back(tbl[i].b2);
            stim.push_back(tbl[i].b3);
            exp_q.push_back('{0, tbl[i].word});
            do_load(1, 0);
        end

        // Three words with byte_valid toggling.
        stim.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            stim.push_back(tbl[i + 1].b0);
            stim.push_back(tbl[i + 1].b1);
            stim.push_back(tbl[i + 1].b2);
            stim.push_back(tbl[i + 1].b3);
            exp_q.push_back('{i, tbl[i + 1].word});
        end
        do_load(3, 1);

        // Rejection, zero length, and the capacity boundary.
        rand_load(33, 0);
        rand_load(0, 0);
        rand_load(127, 0);
        rand_load(32, 0);

        // Start while busy is ignored: load continues with the latched count.
        begin
            int wr0;
            stim.delete();
            exp_q.delete();
            for (int i = 0; i < 8; i++) stim.push_back(8'(i * 37 + 5));
            exp_q.push_back('{0, {stim[3], stim[2], stim[1], stim[0]}});
            exp_q.push_back('{1, {stim[7], stim[6], stim[5], stim[4]}});
            wr0 = n_wr;
            start = 1'b1;
            num_words = 7'd2;
            tick();
            start = 1'b0;
            tick();
            feed(0, 5, 0);
            start = 1'b1;
            num_words = 7'd1;
            tick();
            start = 1'b0;
            @(negedge clk);
            check("busy_start_busy", 32'(busy_a), 32'd1);
            check("busy_start_wl", 32'(wl_a), 32'd1);
            tick();
            feed(5, 3, 0);
            finish_load(2, wr0);
        end

        // Reset mid-load after word 0 and two bytes of word 1.
        begin
            int wr0;
            stim.delete();
            exp_q.delete();
            for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
            exp_q.push_back('{0, {stim[3], stim[2], stim[1], stim[0]}});
            wr0 = n_wr;
            start = 1'b1;
            num_words = 7'd2;
            tick();
            start = 1'b0;
            tick();
            feed(0, 6, 0);
            check("pre_rst_writes", 32'(n_wr - wr0), 32'd1);
            reset = 1'b1;
            byte_valid = 1'b1;
            @(negedge clk);
            check("rst_mid_wr_en", 32'(wr_en_a), 32'd0);
            check("rst_mid_ready", 32'(byte_ready_a), 32'd0);
            tick();
            reset = 1'b0;
            byte_valid = 1'b0;
            @(negedge clk);
            check("post_rst_ready", 32'(byte_ready_a), 32'd0);
            check("post_rst_busy", 32'(busy_a), 32'd0);
            check("post_rst_done", 32'(done_a), 32'd0);
            check("post_rst_err", 32'(err_a), 32'd0);
            check("post_rst_wl", 32'(wl_a), 32'd0);
            check("post_rst_wr_data", wr_data_a, 32'd0);
            check("post_rst_wr_addr", wr_addr_a, 32'd0);
            repeat (4) tick();
            check("post_rst_writes", 32'(n_wr - wr0), 32'd1);
            last_wl = 0;
            rand_load(1, 0);
        end

        // Randomized loads against the model.
        for (int it = 0; it < 30; it++) begin
            int r;
            int n;
            r = $urandom_range(0, 9);
            if (r == 0) n = 0;
            else if (r == 1) n = $urandom_range(33, 127);
            else n = $urandom_range(1, 6);
            rand_load(n, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory of the single-cycle processor. It accepts a little-endian byte stream over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit instruction word. It issues one write per word into the instruction memory at consecutive word-aligned byte addresses (BASE_ADDR, BASE_ADDR+4, ...). It is the writer side of the instruction memory: the core only reads that memory by PC.

## Interface
- BASE_ADDR, 0: byte address of the first word written; must be a multiple of 4.
- MAX_WORDS, 32: capacity in words; 128-entry memory indexed by byte address at multiples of 4.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- num_words  input  7  number of words to load; latched on start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the write: BASE_ADDR + 4*index.
- wr_data  output  32  assembled instruction word.
- busy  output  1  high in RECV and WRITE.
- done  output  1  one-cycle pulse at end of load.
- err  output  1  valid with done; load was rejected (num_words > MAX_WORDS).
- words_loaded  output  7  count of words written in the current/last load.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: byte_ready=0, wr_en=0. On start=1:
  - num_words==0 → DONE, err=0.
  - num_words>MAX_WORDS → DONE, err=1; nothing written.
  - Otherwise latch num_words, clear byte index, word index and words_loaded, then → RECV.
- RECV: byte_ready=1. A byte is accepted when byte_valid && byte_ready.
  - Byte k (0..3) goes into word bits [8k+7:8k], little-endian: byte 0 → [7:0].
  - The byte index increments mod 4. On acceptance of byte 3 → WRITE.
- WRITE: byte_ready=0. wr_en=1, wr_addr=BASE_ADDR+4*word_index, wr_data=assembled word.
  - word_index and words_loaded increment.
  - If the new count == num_words → DONE, else → RECV.
- DONE: done=1 and err held for one cycle, then → IDLE. err clears on the next start.
- start is ignored outside IDLE. byte_valid is ignored outside RECV; no byte is consumed.
- Address arithmetic is 32-bit. word_index is limited by MAX_WORDS, so it never wraps.
- words_loaded holds its value in IDLE after a load until the next accepted start.

## Timing
- Reset: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, words_loaded=0. The assembly register and indices are cleared.
- Reset mid-load aborts immediately. No wr_en is issued after reset is asserted. A partially assembled word is discarded.
- start accepted in cycle T: byte_ready=1 from T+1.
- 4th byte accepted in cycle N: wr_en=1 in cycle N+1 only; byte_ready=0 in N+1; byte_ready=1 again in N+2 if more words remain.
- Last write in cycle W: done=1 in W+1, IDLE in W+2, so a new start is accepted from W+2.
- Best-case throughput: 5 cycles per word. Gaps in byte_valid stall without losing the byte index.
- Rejected or zero-length start in cycle T: done=1 (err as above) in T+1.

## Test plan
- Single word: num_words=1, bytes 0x93,0x00,0xA0,0x00 back-to-back → one wr_en with wr_addr=0x0, wr_data=0x00A00093; done 1 cycle after the write; words_loaded=1, err=0.
- Three words with byte_valid toggling every other cycle; words 0x00100083, 0x00200103, 0x002081B3 → writes at 0x0, 0x4, 0x8 in order; exactly 3 wr_en pulses; byte_ready low in each WRITE cycle.
- BASE_ADDR=0x10, num_words=2 → wr_addr 0x10 then 0x14.
- num_words=33 (MAX_WORDS=32) → done=1 and err=1 one cycle after start; no wr_en; byte_ready never high.
- num_words=0 → done=1, err=0 next cycle; no writes. A start pulse while busy does not restart the load or clear words_loaded.
- reset asserted after 2 of 4 bytes of word 1 (after word 0 was written) → no further wr_en; all outputs at reset values next cycle; a new load of 1 word writes at BASE_ADDR with the correct data.
